// File: rtl/imem_dual_fetch_pkg.sv
// Shared constants and FSM state type for the dual-issue instruction fetch memory.
package imem_dual_fetch_pkg;
   localparam int XLEN = 32;
   localparam logic [XLEN-1:0] NOP_INST = 32'h00000013;

   typedef enum logic {INIT, RUN} fsm_t;
endpackage

// File: rtl/imem_dual_fetch_bank.sv
// DEPTH x XLEN storage: one write port, two registered read ports sharing a read enable.
module imem_bank
   import imem_dual_fetch_pkg::*;
#(
   parameter int              DEPTH    = 256,
   parameter int              AW       = $clog2(DEPTH),
   parameter logic [XLEN-1:0] RST_WORD = NOP_INST
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            we,
   input  logic [AW-1:0]   waddr,
   input  logic [XLEN-1:0] wdata,
   input  logic            re,
   input  logic [AW-1:0]   raddr0,
   input  logic [AW-1:0]   raddr1,
   output logic [XLEN-1:0] rdata0,
   output logic [XLEN-1:0] rdata1
);
   logic [XLEN-1:0] mem [DEPTH];

   // NOTE: the array is deliberately left out of reset so it maps onto RAM; the clear sweep fills it.
   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

   // NOTE: non-blocking assignment makes a same-edge write invisible to these reads (read-before-write).
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rdata0 <= RST_WORD;
         rdata1 <= RST_WORD;
      end else if (re) begin
         rdata0 <= mem[raddr0];
         rdata1 <= mem[raddr1];
      end
   end
endmodule

// File: rtl/imem_dual_fetch.sv
// Instruction memory with a clear sweep after reset and a one-cycle, one- or two-wide fetch port.
module imem_dual_fetch #(
   parameter int          DEPTH    = 256,
   parameter int          ISSUE_W  = 2,
   parameter logic [31:0] NOP_INST = imem_dual_fetch_pkg::NOP_INST
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     req_valid,
   output logic                     req_ready,
   input  logic [31:0]              req_pc,
   output logic                     rsp_valid,
   input  logic                     rsp_ready,
   output logic [31:0]              rsp_pc,
   output logic [31:0]              rsp_inst0,
   output logic [31:0]              rsp_inst1,
   output logic                     rsp_slot1_vld,
   output logic                     rsp_fault,
   input  logic                     flush,
   input  logic                     ld_en,
   input  logic [$clog2(DEPTH)-1:0] ld_addr,
   input  logic [31:0]              ld_data,
   output logic                     init_busy
);
   import imem_dual_fetch_pkg::*;

   localparam int AW = $clog2(DEPTH);

   fsm_t            state;
   logic [AW-1:0]   init_cnt;
   logic            accept;
   logic [AW-1:0]   idx;
   logic            fault;
   logic            slot1;
   logic            we;
   logic [AW-1:0]   waddr;
   logic [XLEN-1:0] wdata;
   logic [XLEN-1:0] bank_q0;
   logic [XLEN-1:0] bank_q1;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= INIT;
         init_cnt  <= '0;
         init_busy <= 1'b1;
      end else begin
         case (state)
            INIT: begin
               init_cnt <= init_cnt + 1'b1;
               if (init_cnt == AW'(DEPTH - 1)) begin
                  state     <= RUN;
                  init_busy <= 1'b0;
               end
            end
            RUN: ;
         endcase
      end
   end

   assign req_ready = (state == RUN) && (!rsp_valid || rsp_ready) && !flush;
   assign accept    = req_valid && req_ready;

   assign idx   = req_pc[AW+1:2];
   assign fault = (req_pc[1:0] != 2'b00) || (req_pc[XLEN-1:AW+2] != '0);
   // The second slot never wraps from the last word back to word 0.
   assign slot1 = (ISSUE_W == 2) && !fault && (idx != AW'(DEPTH - 1));

   // The sweep owns the write port during INIT, so program loads are dropped then.
   assign we    = (state == INIT) || ld_en;
   assign waddr = (state == INIT) ? init_cnt : ld_addr;
   assign wdata = (state == INIT) ? NOP_INST : ld_data;

   imem_bank #(
      .DEPTH    (DEPTH),
      .AW       (AW),
      .RST_WORD (NOP_INST)
   ) u_bank (
      .clk    (clk),
      .rst    (rst),
      .we     (we),
      .waddr  (waddr),
      .wdata  (wdata),
      .re     (accept),
      .raddr0 (idx),
      .raddr1 (idx + 1'b1),
      .rdata0 (bank_q0),
      .rdata1 (bank_q1)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rsp_valid     <= 1'b0;
         rsp_pc        <= '0;
         rsp_fault     <= 1'b0;
         rsp_slot1_vld <= 1'b0;
      end else if (accept) begin
         rsp_valid     <= 1'b1;
         rsp_pc        <= req_pc;
         rsp_fault     <= fault;
         rsp_slot1_vld <= slot1;
      end else if (flush || rsp_ready) begin
         rsp_valid     <= 1'b0;
      end
   end

   // Substitution uses registered flags, so the outputs stay frozen with the bank registers.
   assign rsp_inst0 = rsp_fault     ? NOP_INST : bank_q0;
   assign rsp_inst1 = rsp_slot1_vld ? bank_q1  : NOP_INST;
endmodule

// File: tb/tb_imem_dual_fetch.sv
// Self-checking bench for imem_dual_fetch against an array-based fetch model.
module tb_imem_dual_fetch;
   localparam int          DEPTH = 256;
   localparam int          AW    = $clog2(DEPTH);
   localparam logic [31:0] NOP   = 32'h00000013;

   typedef struct packed {
      logic        valid;
      logic        fault;
      logic        slot1;
      logic [31:0] pc;
      logic [31:0] i0;
      logic [31:0] i1;
   } rsp_t;

   localparam rsp_t RST_RSP = {1'b0, 1'b0, 1'b0, 32'h0, NOP, NOP};

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          req_valid = 1'b0;
   logic          req_ready;
   logic [31:0]   req_pc = '0;
   logic          rsp_valid;
   logic          rsp_ready = 1'b0;
   logic [31:0]   rsp_pc;
   logic [31:0]   rsp_inst0;
   logic [31:0]   rsp_inst1;
   logic          rsp_slot1_vld;
   logic          rsp_fault;
   logic          flush = 1'b0;
   logic          ld_en = 1'b0;
   logic [AW-1:0] ld_addr = '0;
   logic [31:0]   ld_data = '0;
   logic          init_busy;

   int n_cmp = 0;
   int n_bad = 0;

   // Reference model state.
   logic [31:0] m_mem [DEPTH];
   rsp_t        m_rsp = RST_RSP;
   int          m_init_left = DEPTH;

   // Observations captured by tick() before the edge.
   logic obs_ready, obs_busy, exp_ready;
   rsp_t pre_obs;

   imem_dual_fetch dut (
      .clk           (clk),
      .rst           (rst),
      .req_valid     (req_valid),
      .req_ready     (req_ready),
      .req_pc        (req_pc),
      .rsp_valid     (rsp_valid),
      .rsp_ready     (rsp_ready),
      .rsp_pc        (rsp_pc),
      .rsp_inst0     (rsp_inst0),
      .rsp_inst1     (rsp_inst1),
      .rsp_slot1_vld (rsp_slot1_vld),
      .rsp_fault     (rsp_fault),
      .flush         (flush),
      .ld_en         (ld_en),
      .ld_addr       (ld_addr),
      .ld_data       (ld_data),
      .init_busy     (init_busy)
   );

   always #5 clk = ~clk;

   function automatic rsp_t dut_rsp();
      return {rsp_valid, rsp_fault, rsp_slot1_vld, rsp_pc, rsp_inst0, rsp_inst1};
   endfunction

   // What a fetch of pc should return, from the memory contents as seen before this edge.
   function automatic rsp_t predict(input logic [31:0] pc);
      rsp_t        r;
      int unsigned idx;
      idx     = pc / 4;
      r.valid = 1'b1;
      r.pc    = pc;
      r.fault = (pc % 4 != 0) || (pc >= 4 * DEPTH);
      r.slot1 = !r.fault && (idx < DEPTH - 1);
      r.i0    = NOP;
      r.i1    = NOP;
      if (!r.fault) r.i0 = m_mem[idx];
      if (r.slot1)  r.i1 = m_mem[idx + 1];
      return r;
   endfunction

   // Drive one cycle of inputs at edge+1, sample at edge+2, advance the model at the edge.
   task automatic tick(input logic v, input logic [31:0] pc, input logic rr, input logic fl,
                       input logic le, input logic [AW-1:0] la, input logic [31:0] ld);
      req_valid = v; req_pc = pc; rsp_ready = rr; flush = fl;
      ld_en = le; ld_addr = la; ld_data = ld;
      #1;
      obs_ready = req_ready;
      obs_busy  = init_busy;
      pre_obs   = dut_rsp();
      exp_ready = (m_init_left == 0) && (!m_rsp.valid || rr) && !fl;
      @(posedge clk);
      if (m_init_left > 0) begin
         m_mem[DEPTH - m_init_left] = NOP;
         m_init_left--;
      end else begin
         if (exp_ready && v)  m_rsp = predict(pc);
         else if (fl || rr)   m_rsp.valid = 1'b0;
         if (le) m_mem[la] = ld;
      end
      #1;
   endtask

   task automatic model_reset();
      m_rsp       = RST_RSP;
      m_init_left = DEPTH;
   endtask

   task automatic release_reset();
      @(posedge clk);
      #1 rst = 1'b0;
   endtask

   task automatic sweep(input logic v, output int busy_cycles, output int ready_hi);
      busy_cycles = 0;
      ready_hi    = 0;
      for (int i = 0; i < DEPTH + 40; i++) begin
         tick(v, 32'h0, 1'b1, 1'b0, 1'b0, '0, '0);
         if (!obs_busy) break;
         busy_cycles++;
         if (obs_ready) ready_hi++;
      end
   endtask

   task automatic test_reset();
      int busy_cycles, ready_hi;
      rsp_t exp;
      req_valid = 1'b1; rsp_ready = 1'b1;
      @(posedge clk);
      #1;
      n_cmp++; if (dut_rsp() !== RST_RSP) begin n_bad++;
         $display("FAIL reset_rsp got %h want %h", dut_rsp(), RST_RSP); end
      n_cmp++; if (init_busy !== 1'b1) begin n_bad++;
         $display("FAIL reset_busy got %b want 1", init_busy); end
      n_cmp++; if (req_ready !== 1'b0) begin n_bad++;
         $display("FAIL reset_ready got %b want 0", req_ready); end
      model_reset();
      release_reset();
      sweep(1'b1, busy_cycles, ready_hi);
      n_cmp++; if (busy_cycles != DEPTH) begin n_bad++;
         $display("FAIL sweep_len got %0d want %0d", busy_cycles, DEPTH); end
      n_cmp++; if (ready_hi != 0) begin n_bad++;
         $display("FAIL sweep_ready got %0d cycles high want 0", ready_hi); end
      exp = {1'b1, 1'b0, 1'b1, 32'h0, NOP, NOP};
      n_cmp++; if (dut_rsp() !== exp) begin n_bad++;
         $display("FAIL first_fetch got %h want %h", dut_rsp(), exp); end
   endtask

   task automatic test_load_fetch();
      rsp_t exp;
      tick(1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 8'd2, 32'h00500093);
      tick(1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 8'd3, 32'h00700093);
      tick(1'b1, 32'h8, 1'b1, 1'b0, 1'b0, '0, '0);
      exp = {1'b1, 1'b0, 1'b1, 32'h8, 32'h00500093, 32'h00700093};
      n_cmp++; if (dut_rsp() !== exp) begin n_bad++;
         $display("FAIL load_fetch got %h want %h", dut_rsp(), exp); end
   endtask

   task automatic test_boundary();
      logic [31:0] pcs [3];
      rsp_t        exps [3];
      pcs[0] = 32'h3FC; exps[0] = {1'b1, 1'b0, 1'b0, 32'h3FC, NOP, NOP};
      pcs[1] = 32'h6;   exps[1] = {1'b1, 1'b1, 1'b0, 32'h6,   NOP, NOP};
      pcs[2] = 32'h400; exps[2] = {1'b1, 1'b1, 1'b0, 32'h400, NOP, NOP};
      for (int i = 0; i < 3; i++) begin
         tick(1'b1, pcs[i], 1'b1, 1'b0, 1'b0, '0, '0);
         n_cmp++; if (dut_rsp() !== exps[i]) begin n_bad++;
            $display("FAIL boundary pc=%h got %h want %h", pcs[i], dut_rsp(), exps[i]); end
      end
      tick(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, '0, '0);
   endtask

   task automatic test_back_to_back();
      logic [31:0] got [$];
      logic [31:0] want [3];
      logic [31:0] pcs  [5];
      logic        vs   [5];
      logic        rrs  [5];
      rsp_t        held;
      want[0] = 32'h0; want[1] = 32'h8; want[2] = 32'h10;
      pcs = '{32'h0, 32'h8, 32'h10, 32'h10, 32'h0};
      vs  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
      rrs = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
      held = {1'b1, 1'b0, 1'b1, 32'h8, 32'h00500093, 32'h00700093};
      for (int i = 0; i < 5; i++) begin
         tick(vs[i], pcs[i], rrs[i], 1'b0, 1'b0, '0, '0);
         if (pre_obs.valid && rrs[i]) got.push_back(pre_obs.pc);
         if (i == 2) begin
            n_cmp++; if (obs_ready !== 1'b0) begin n_bad++;
               $display("FAIL stall_ready got %b want 0", obs_ready); end
            n_cmp++; if (dut_rsp() !== held || pre_obs !== held) begin n_bad++;
               $display("FAIL stall_hold before %h after %h want %h", pre_obs, dut_rsp(), held); end
         end
      end
      n_cmp++; if (got.size() != 3) begin n_bad++;
         $display("FAIL b2b_count got %0d want 3", got.size()); end
      for (int i = 0; i < 3 && i < got.size(); i++) begin
         n_cmp++; if (got[i] !== want[i]) begin n_bad++;
            $display("FAIL b2b_order[%0d] got %h want %h", i, got[i], want[i]); end
      end
   endtask

   task automatic test_rbw();
      tick(1'b1, 32'h10, 1'b1, 1'b0, 1'b1, 8'd4, 32'h00002083);
      n_cmp++; if (rsp_inst0 !== NOP || rsp_pc !== 32'h10 || rsp_valid !== 1'b1) begin n_bad++;
         $display("FAIL rbw_old got inst0=%h pc=%h v=%b want inst0=%h", rsp_inst0, rsp_pc, rsp_valid, NOP); end
      tick(1'b1, 32'h10, 1'b1, 1'b0, 1'b0, '0, '0);
      n_cmp++; if (rsp_inst0 !== 32'h00002083) begin n_bad++;
         $display("FAIL rbw_new got %h want 00002083", rsp_inst0); end
      tick(1'b1, 32'hC, 1'b1, 1'b0, 1'b0, '0, '0);
      n_cmp++; if (rsp_inst0 !== 32'h00700093 || rsp_inst1 !== 32'h00002083) begin n_bad++;
         $display("FAIL rbw_slot1 got %h/%h want 00700093/00002083", rsp_inst0, rsp_inst1); end
   endtask

   task automatic test_flush();
      tick(1'b1, 32'h8, 1'b0, 1'b0, 1'b0, '0, '0);
      tick(1'b1, 32'h10, 1'b1, 1'b1, 1'b0, '0, '0);
      n_cmp++; if (obs_ready !== 1'b0) begin n_bad++;
         $display("FAIL flush_ready got %b want 0", obs_ready); end
      n_cmp++; if (rsp_valid !== 1'b0) begin n_bad++;
         $display("FAIL flush_valid got %b want 0", rsp_valid); end
      tick(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, '0, '0);
      n_cmp++; if (rsp_valid !== 1'b0) begin n_bad++;
         $display("FAIL flush_noaccept got %b want 0", rsp_valid); end
   endtask

   task automatic test_random();
      logic [31:0] pc;
      int          sel;
      for (int i = 0; i < 400; i++) begin
         sel = $urandom_range(0, 9);
         if (sel <= 6)      pc = 32'($urandom_range(0, DEPTH - 1)) << 2;
         else if (sel == 7) pc = 32'(4 * (DEPTH - 1));
         else if (sel == 8) pc = 32'($urandom_range(0, 4 * DEPTH - 1)) | 32'h1;
         else               pc = 32'(4 * DEPTH) + (32'($urandom_range(0, 1000)) << 2);
         tick($urandom_range(0, 9) < 7, pc, $urandom_range(0, 9) < 7, $urandom_range(0, 9) == 0,
              $urandom_range(0, 9) < 3, AW'($urandom), $urandom);
         n_cmp++; if (obs_ready !== exp_ready) begin n_bad++;
            $display("FAIL rand_ready[%0d] got %b want %b", i, obs_ready, exp_ready); end
         n_cmp++; if (dut_rsp() !== m_rsp) begin n_bad++;
            $display("FAIL rand_rsp[%0d] got %h want %h", i, dut_rsp(), m_rsp); end
      end
   endtask

   task automatic test_reset_run();
      int   busy_cycles, ready_hi;
      rsp_t exp;
      tick(1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 8'd2, 32'h00500093);
      tick(1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 8'd5, 32'hABCD0013);
      tick(1'b1, 32'h8, 1'b0, 1'b0, 1'b0, '0, '0);
      n_cmp++; if (rsp_inst0 !== 32'h00500093 || rsp_valid !== 1'b1) begin n_bad++;
         $display("FAIL prerst_hold got %h v=%b want 00500093 v=1", rsp_inst0, rsp_valid); end
      req_valid = 1'b1; rsp_ready = 1'b1; ld_en = 1'b0;
      #2 rst = 1'b1;
      #1;
      n_cmp++; if (dut_rsp() !== RST_RSP || init_busy !== 1'b1 || req_ready !== 1'b0) begin n_bad++;
         $display("FAIL async_rst got %h busy=%b ready=%b want %h busy=1 ready=0",
                  dut_rsp(), init_busy, req_ready, RST_RSP); end
      model_reset();
      release_reset();
      sweep(1'b0, busy_cycles, ready_hi);
      n_cmp++; if (busy_cycles != DEPTH || ready_hi != 0) begin n_bad++;
         $display("FAIL resweep got %0d busy / %0d ready want %0d / 0", busy_cycles, ready_hi, DEPTH); end
      tick(1'b1, 32'h8, 1'b1, 1'b0, 1'b0, '0, '0);
      exp = {1'b1, 1'b0, 1'b1, 32'h8, NOP, NOP};
      n_cmp++; if (dut_rsp() !== exp) begin n_bad++;
         $display("FAIL cleared_w2 got %h want %h", dut_rsp(), exp); end
      tick(1'b1, 32'h14, 1'b1, 1'b0, 1'b0, '0, '0);
      exp = {1'b1, 1'b0, 1'b1, 32'h14, NOP, NOP};
      n_cmp++; if (dut_rsp() !== exp) begin n_bad++;
         $display("FAIL cleared_w5 got %h want %h", dut_rsp(), exp); end
   endtask

   initial begin
      test_reset();
      test_load_fetch();
      test_boundary();
      test_back_to_back();
      test_rbw();
      test_flush();
      test_random();
      test_reset_run();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog expired at %0t", $time);
      $fatal(1, "watchdog");
   end
endmodule

// File: doc/imem_dual_fetch.md
IMEM_DUAL_FETCH -- requirements
Module: imem_dual_fetch

Interface
REQ-001 SHALL have parameter DEPTH, default 256: instruction words stored; power of two, 16..4096.
REQ-002 SHALL have parameter ISSUE_W, default 2: instructions returned per fetch; legal values 1 or 2.
REQ-003 SHALL have parameter NOP_INST, default 32'h00000013: fill and substitute word (ADDI x0,x0,0).
REQ-004 clk  in  1  sole clock; all state changes on rising edge.
REQ-005 rst  in  1  reset; asynchronous, active-high.
REQ-006 req_valid  in  1  fetch request present.
REQ-007 req_ready  out  1  fetch request accepted this cycle when high with req_valid.
REQ-008 req_pc  in  32  byte address of first instruction.
REQ-009 rsp_valid  out  1  response registers hold a valid fetch.
REQ-010 rsp_ready  in  1  consumer takes the response.
REQ-011 rsp_pc  out  32  req_pc of the held response.
REQ-012 rsp_inst0 / rsp_inst1  out  32 each  instruction at rsp_pc / rsp_pc+4.
REQ-013 rsp_slot1_vld  out  1  rsp_inst1 is a real instruction.
REQ-014 rsp_fault  out  1  fetch was misaligned or out of range.
REQ-015 flush  in  1  discard held response (branch redirect).
REQ-016 ld_en, ld_addr[$clog2(DEPTH)-1:0], ld_data[31:0]  in  program-load write port, word addressed.
REQ-017 init_busy  out  1  memory clear sweep in progress.

Function
REQ-018 SHALL implement FSM states INIT and RUN; INIT -> RUN after exactly DEPTH cycles, RUN is terminal until rst.
REQ-019 In INIT SHALL write NOP_INST to word init_cnt each cycle, init_cnt 0..DEPTH-1; init_busy=1; req_ready=0; ld_en ignored.
REQ-020 In RUN, req_ready SHALL equal (!rsp_valid || rsp_ready) && !flush.
REQ-021 Accepted request SHALL produce registered response on the next edge: latency exactly 1 cycle, throughput 1 fetch/cycle when rsp_ready held high.
REQ-022 While rsp_valid && !rsp_ready, all rsp_* outputs SHALL stay stable.
REQ-023 flush SHALL clear rsp_valid on the next edge and block acceptance in its cycle; flush with rsp_ready both high is still a flush.
REQ-024 Word index = req_pc[$clog2(DEPTH)+1:2]; req_pc[1:0]!=0 or req_pc >= 4*DEPTH SHALL set rsp_fault=1, rsp_inst0=rsp_inst1=NOP_INST, rsp_slot1_vld=0.
REQ-025 rsp_slot1_vld SHALL be 1 only when ISSUE_W==2, no fault, and index < DEPTH-1; no wrap-around to word 0; otherwise rsp_inst1=NOP_INST.
REQ-026 ld_en in RUN SHALL write ld_data to ld_addr on the edge.
REQ-027 Load write and fetch of the same word in one cycle SHALL return the old word (read-before-write).
REQ-028 rsp_pc SHALL equal the accepted req_pc unchanged, including faulted fetches.

Reset
REQ-029 rst high SHALL asynchronously force state=INIT, init_cnt=0, rsp_valid=0, rsp_fault=0, rsp_slot1_vld=0, rsp_pc=0, rsp_inst0=rsp_inst1=NOP_INST, init_busy=1.
REQ-030 rst asserted mid-INIT or mid-RUN SHALL restart the full DEPTH-cycle sweep; in-flight response lost; memory array itself not reset except by sweep.

Structure
REQ-031 Shared package SHALL hold NOP_INST constant, XLEN=32, and the fsm state typedef (INIT, RUN).
REQ-032 Storage SHALL be one sub-module imem_bank: DEPTH x 32, one write port, two registered read ports.

Verification
REQ-033 Reset release, DEPTH=256: init_busy high 256 cycles, req_ready=0 throughout; then fetch pc=0x0 -> inst0=inst1=0x00000013, slot1_vld=1.
REQ-034 Load words 2,3 = 0x00500093, 0x00700093; fetch pc=0x8 -> next cycle rsp_inst0=0x00500093, rsp_inst1=0x00700093, slot1_vld=1, fault=0.
REQ-035 Fetch pc=0x3FC (last word) -> slot1_vld=0, inst1=0x00000013; pc=0x6 -> fault=1; pc=0x400 -> fault=1, both NOP.
REQ-036 Back-to-back fetches 0x0,0x8,0x10 with rsp_ready low cycle 2 -> response 0x8 held stable, req_ready=0, no fetch dropped or duplicated.
REQ-037 ld_en to word 4 with data 0x00002083 same cycle as fetch pc=0x10 -> response old word; refetch returns 0x00002083.
REQ-038 flush with rsp_valid=1 -> rsp_valid=0 next cycle; rst pulsed in RUN -> init_busy=1, prior loads cleared to NOP after sweep.
